// File: rtl/alu_slice_pkg.sv
// Shared constants, FSM state type and X/Y operand selectors for the
// multi-cycle ALU slice engine.
package alu_slice_pkg;

  localparam int SLICE_W = 4;

  // Function selects as seen on S[0:3] (S3 first).
  localparam logic [3:0] FN_A         = 4'b0000;
  localparam logic [3:0] FN_A_TIMES_2 = 4'b0011;
  localparam logic [3:0] FN_A_PLUS_B  = 4'b0110;
  localparam logic [3:0] FN_XNOR      = 4'b0110;
  localparam logic [3:0] FN_A_MINUS_B = 4'b1001;
  localparam logic [3:0] FN_ZERO      = 4'b1100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // s is little-endian here: s[3]=S3 ... s[0]=S0.
  function automatic logic [SLICE_W-1:0] sel_x(input logic [3:0] s,
                                               input logic [SLICE_W-1:0] a,
                                               input logic [SLICE_W-1:0] b);
    logic [SLICE_W-1:0] x;
    case (s[3:2])
      2'b00:   x = a;
      2'b01:   x = a | b;
      2'b10:   x = a | ~b;
      default: x = '1;
    endcase
    return x;
  endfunction

  function automatic logic [SLICE_W-1:0] sel_y(input logic [3:0] s,
                                               input logic [SLICE_W-1:0] a,
                                               input logic [SLICE_W-1:0] b);
    logic [SLICE_W-1:0] y;
    case (s[1:0])
      2'b00:   y = '0;
      2'b01:   y = a & ~b;
      2'b10:   y = a & b;
      default: y = a;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/alu_slice_if.sv
// Request/response bundle of the ALU engine. Vectors are big-endian:
// bit 0 is the MSB, matching the original slice pinout.
interface alu_slice_if #(
  parameter int WIDTH = 36
);
  // Both sides use strict valid/ready: a transfer happens on the rising edge
  // where valid & ready are both 1; valid never waits on ready, and the
  // payload is held stable while valid is high and ready is low.
  logic             in_valid;
  logic             in_ready;
  logic [0:3]       S;
  logic             M;
  logic [0:WIDTH-1] A;
  logic [0:WIDTH-1] B;
  logic             CIN;
  logic             out_valid;
  logic             out_ready;
  logic [0:WIDTH-1] F;
  logic             COUT;
  logic             OVF;
  logic             ZERO;

  modport master (
    output in_valid, S, M, A, B, CIN, out_ready,
    input  in_ready, out_valid, F, COUT, OVF, ZERO
  );

  modport slave (
    input  in_valid, S, M, A, B, CIN, out_ready,
    output in_ready, out_valid, F, COUT, OVF, ZERO
  );
endinterface

// File: rtl/alu_slice_seq_alu4_slice.sv
// One combinational 4-bit ALU slice: X/Y generation, ripple carry, and the
// carry into its top bit (needed for signed overflow at the word MSB).
module alu4_slice
  import alu_slice_pkg::*;
(
  input  logic [3:0]         s,
  input  logic               m,
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] f,
  output logic               cout,
  output logic               c_msb
);

  logic [SLICE_W-1:0] x;
  logic [SLICE_W-1:0] y;
  logic [SLICE_W-1:0] p;
  logic [SLICE_W-1:0] g;

  assign x = sel_x(s, a, b);
  assign y = sel_y(s, a, b);
  assign p = x ^ y;
  assign g = x & y;

  // Carries are always computed so COUT stays meaningful in logic mode.
  always_comb begin
    logic carry;
    carry = cin;
    f     = '0;
    c_msb = 1'b0;
    for (int i = 0; i < SLICE_W; i++) begin
      if (i == SLICE_W - 1) c_msb = carry;
      f[i]  = m ? ~p[i] : (p[i] ^ carry);
      carry = g[i] | (p[i] & carry);
    end
    cout = carry;
  end

endmodule

// File: rtl/alu_slice_seq.sv
// Multi-cycle WIDTH-bit ALU: SLICES_PER_CYCLE chained 4-bit slices per clock,
// least-significant group first, with the group carry registered between passes.
module alu_slice_seq
  import alu_slice_pkg::*;
#(
  parameter int WIDTH            = 36,
  parameter int SLICES_PER_CYCLE = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_slice_if.slave     bus,
  output state_t         dbg_state
);

  localparam int GW   = SLICE_W * SLICES_PER_CYCLE;
  localparam int ITER = (GW > 0) ? WIDTH / GW : 1;
  localparam int IW   = (ITER > 1) ? $clog2(ITER) : 1;

  if (SLICES_PER_CYCLE < 1 || WIDTH < GW || (WIDTH % GW) != 0) begin : g_bad_width
    $error("alu_slice_seq: WIDTH must be a positive multiple of 4*SLICES_PER_CYCLE");
  end

  state_t            state_q, state_d;
  logic [IW-1:0]     iter_q, iter_d;
  logic              carry_q, carry_d;
  logic [3:0]        s_q, s_d;
  logic              m_q, m_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic [WIDTH-1:0]  f_q, f_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;
  logic              zero_q, zero_d;

  logic              in_ready;
  logic              out_valid;
  logic              accept;
  logic [GW-1:0]     grp_a;
  logic [GW-1:0]     grp_b;
  logic [GW-1:0]     grp_f;
  logic              grp_cout;
  logic              grp_cmsb;

  assign grp_a = a_q[int'(iter_q) * GW +: GW];
  assign grp_b = b_q[int'(iter_q) * GW +: GW];

  for (genvar i = 0; i < SLICES_PER_CYCLE; i++) begin : g_sl
    logic               ci;
    logic               co;
    logic               cm;
    logic [SLICE_W-1:0] fo;

    if (i == 0) begin : g_first
      assign ci = carry_q;
    end else begin : g_next
      assign ci = g_sl[i-1].co;
    end

    alu4_slice u_slice (
      .s     (s_q),
      .m     (m_q),
      .a     (grp_a[i*SLICE_W +: SLICE_W]),
      .b     (grp_b[i*SLICE_W +: SLICE_W]),
      .cin   (ci),
      .f     (fo),
      .cout  (co),
      .c_msb (cm)
    );

    assign grp_f[i*SLICE_W +: SLICE_W] = fo;
  end

  assign grp_cout = g_sl[SLICES_PER_CYCLE-1].co;
  assign grp_cmsb = g_sl[SLICES_PER_CYCLE-1].cm;

  always_comb begin
    state_d   = state_q;
    iter_d    = iter_q;
    carry_d   = carry_q;
    s_d       = s_q;
    m_d       = m_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    f_d       = f_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
    zero_d    = zero_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        accept   = bus.in_valid;
      end
      RUN: begin
        res_d[int'(iter_q) * GW +: GW] = grp_f;
        carry_d = grp_cout;
        if (iter_q == IW'(ITER - 1)) begin
          // Visible outputs change only here, so the previous result stays
          // on F/flags for the whole of RUN.
          state_d = DONE;
          iter_d  = '0;
          f_d     = res_d;
          cout_d  = grp_cout;
          ovf_d   = grp_cmsb ^ grp_cout;
          zero_d  = (res_d == '0);
        end else begin
          iter_d = iter_q + IW'(1);
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready) begin
          in_ready = 1'b1;
          accept   = bus.in_valid;
          if (!bus.in_valid) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      state_d = RUN;
      iter_d  = '0;
      carry_d = bus.CIN;
      s_d     = bus.S;
      m_d     = bus.M;
      a_d     = bus.A;
      b_d     = bus.B;
      res_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      iter_q  <= '0;
      carry_q <= 1'b0;
      s_q     <= '0;
      m_q     <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      f_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      carry_q <= carry_d;
      s_q     <= s_d;
      m_q     <= m_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      f_q     <= f_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.F         = f_q;
  assign bus.COUT      = cout_q;
  assign bus.OVF       = ovf_q;
  assign bus.ZERO      = zero_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_alu_slice_seq.sv
// Directed bench for alu_slice_seq: 36-bit/3-slice engine plus a 9-slice
// single-pass variant, checked against hand-computed results.
module tb_alu_slice_seq;
  import alu_slice_pkg::*;

  logic   clk;
  logic   rst_n;
  state_t dbg36;
  state_t dbg9;
  int     n_vec;
  int     n_err;

  alu_slice_if #(.WIDTH(36)) bus36 ();
  alu_slice_if #(.WIDTH(36)) bus9 ();

  alu_slice_seq #(.WIDTH(36), .SLICES_PER_CYCLE(3)) dut36 (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus36),
    .dbg_state (dbg36)
  );

  alu_slice_seq #(.WIDTH(36), .SLICES_PER_CYCLE(9)) dut9 (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus9),
    .dbg_state (dbg9)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks (all driving/sampling happens 1 time unit after posedge)
  task automatic start_op(input logic [3:0] s, input logic m, input logic [35:0] a,
                          input logic [35:0] b, input logic cin);
    bus36.S        = s;
    bus36.M        = m;
    bus36.A        = a;
    bus36.B        = b;
    bus36.CIN      = cin;
    bus36.in_valid = 1'b1;
    @(posedge clk); #1;
    bus36.in_valid = 1'b0;
    bus36.S        = 4'($urandom_range(0, 15));
    bus36.M        = ~m;
    bus36.A        = 36'({$urandom(), $urandom()});
    bus36.B        = 36'({$urandom(), $urandom()});
    bus36.CIN      = ~cin;
  endtask

  task automatic wait_check(input string tag, input int exp_lat, input logic [35:0] ef,
                            input logic ec, input logic eo, input logic ez);
    int lat;
    lat = 0;
    while (bus36.out_valid !== 1'b1 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"},  64'(lat),        64'(exp_lat));
    chk({tag, "_f"},    64'(bus36.F),    64'(ef));
    chk({tag, "_cout"}, 64'(bus36.COUT), 64'(ec));
    chk({tag, "_ovf"},  64'(bus36.OVF),  64'(eo));
    chk({tag, "_zero"}, 64'(bus36.ZERO), 64'(ez));
  endtask

  task automatic handoff();
    bus36.out_ready = 1'b1;
    @(posedge clk); #1;
    bus36.out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus36.in_valid = 1'b0; bus36.out_ready = 1'b0;
    bus36.S = '0; bus36.M = 1'b0; bus36.A = '0; bus36.B = '0; bus36.CIN = 1'b0;
    bus9.in_valid = 1'b0; bus9.out_ready = 1'b0;
    bus9.S = '0; bus9.M = 1'b0; bus9.A = '0; bus9.B = '0; bus9.CIN = 1'b0;

    #2;
    chk("rst_in_ready",  64'(bus36.in_ready),  64'(1));
    chk("rst_out_valid", 64'(bus36.out_valid), 64'(0));
    chk("rst_f",         64'(bus36.F),         64'(0));
    chk("rst_flags",     64'({bus36.COUT, bus36.OVF, bus36.ZERO}), 64'(0));
    chk("rst_state",     64'(dbg36),           64'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // A-B: 5-3
    start_op(FN_A_MINUS_B, 1'b0, 36'd5, 36'd3, 1'b1);
    wait_check("sub", 3, 36'd2, 1'b1, 1'b0, 1'b0);
    handoff();

    // A+1 with carry through every group
    chk("idle_in_ready", 64'(bus36.in_ready), 64'(1));
    start_op(FN_A, 1'b0, 36'hF_FFFF_FFFF, 36'h0, 1'b1);
    wait_check("inc", 3, 36'h0, 1'b1, 1'b0, 1'b1);
    handoff();

    // logic XNOR; COUT still reflects A+B
    start_op(FN_XNOR, 1'b1, 36'hF_0F0F_0F0F, 36'h0_FF00_FF00, 1'b0);
    wait_check("xnor", 3, 36'h0_0FF0_0FF0, 1'b1, 1'b0, 1'b0);
    handoff();

    // signed overflow
    start_op(FN_A_PLUS_B, 1'b0, 36'h7_FFFF_FFFF, 36'h1, 1'b0);
    wait_check("ovf", 3, 36'h8_0000_0000, 1'b0, 1'b1, 1'b0);
    handoff();

    // A+A
    start_op(FN_A_TIMES_2, 1'b0, 36'h0_1234_5678, 36'h0, 1'b0);
    wait_check("dbl", 3, 36'h0_2468_ACF0, 1'b0, 1'b0, 1'b0);
    handoff();

    // backpressure then same-edge accept
    start_op(FN_A_PLUS_B, 1'b0, 36'h1_2345_6789, 36'h1, 1'b0);
    wait_check("bp", 3, 36'h1_2345_678A, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_hold", 64'({bus36.out_valid, bus36.in_ready, bus36.F}),
          64'({1'b1, 1'b0, 36'h1_2345_678A}));
    end
    bus36.S = FN_A_MINUS_B; bus36.M = 1'b0; bus36.CIN = 1'b1;
    bus36.A = 36'h10; bus36.B = 36'h20;
    bus36.in_valid = 1'b1;
    bus36.out_ready = 1'b1;
    #1;
    chk("bp_in_ready", 64'(bus36.in_ready), 64'(1));
    @(posedge clk); #1;
    bus36.in_valid = 1'b0;
    bus36.out_ready = 1'b0;
    bus36.A = 36'h5;
    chk("b2b_run", 64'({bus36.out_valid, dbg36}), 64'({1'b0, RUN}));
    chk("b2b_f_held", 64'(bus36.F), 64'(36'h1_2345_678A));
    wait_check("b2b", 3, 36'hF_FFFF_FFF0, 1'b0, 1'b0, 1'b0);
    handoff();

    // asynchronous reset in the middle of RUN
    start_op(FN_A_PLUS_B, 1'b0, 36'h1, 36'h2, 1'b0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(bus36.out_valid), 64'(0));
    chk("arst_in_ready",  64'(bus36.in_ready),  64'(1));
    chk("arst_f",         64'(bus36.F),         64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("arst_idle", 64'({bus36.out_valid, dbg36}), 64'({1'b0, IDLE}));

    // 9-slice variant: all ones in one pass
    bus9.S = FN_ZERO; bus9.M = 1'b0; bus9.CIN = 1'b0;
    bus9.A = 36'h3_1415_9265; bus9.B = 36'h2_7182_8182;
    bus9.in_valid = 1'b1;
    @(posedge clk); #1;
    bus9.in_valid = 1'b0;
    bus9.A = '0;
    lat = 0;
    while (bus9.out_valid !== 1'b1 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("w9_lat",  64'(lat),          64'(1));
    chk("w9_f",    64'(bus9.F),       64'(36'hF_FFFF_FFFF));
    chk("w9_cout", 64'(bus9.COUT),    64'(0));
    chk("w9_ovf",  64'(bus9.OVF),     64'(0));
    bus9.out_ready = 1'b1;
    @(posedge clk); #1;
    bus9.out_ready = 1'b0;
    chk("w9_idle", 64'({bus9.out_valid, bus9.in_ready, bus9.F}),
        64'({1'b0, 1'b1, 36'hF_FFFF_FFFF}));

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
